sdp_ram_banked: RTL and testbench

Parametrised single-clock simple dual-port RAM: one write port and one read port, with configurable data width, total depth and bank size. Storage is split into 2^(ADDR_W-BANK_AW) banks selected by the upper address bits; a registered bank select steers the read mux. Adds an optional output pipeline register, a read-valid strobe and an optional post-reset clear engine. Serves as the general frame-buffer / program-memory store beside the LCD and CPU blocks.

---
 rtl/sdp_ram_banked_pkg.sv | 13 +
 rtl/sdp_ram_banked_if.sv | 25 ++
 rtl/sdp_ram_banked_bank.sv | 34 +++
 rtl/sdp_ram_banked.sv | 134 +++++++++++++
 tb/tb_sdp_ram_banked.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/sdp_ram_banked_pkg.sv
// Shared types and helpers for the banked simple dual-port RAM.
package sdp_ram_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } clr_state_e;

    function automatic int nb(input int addr_w, input int bank_aw);
        return 1 << (addr_w - bank_aw);
    endfunction

endpackage

// File: rtl/sdp_ram_banked_if.sv
// Write/read port bundle of the banked RAM; master drives, slave is the RAM.
interface sdp_ram_banked_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 15
);
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic              oce;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              init_busy;

    modport master (
        output wr_en, wr_addr, wr_data, rd_en, rd_addr, oce,
        input  rd_data, rd_valid, init_busy
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rd_en, rd_addr, oce,
        output rd_data, rd_valid, init_busy
    );
endinterface

// File: rtl/sdp_ram_banked_bank.sv
// One RAM bank: synchronous write, registered read-first read with local enables.
module sdp_ram_bank #(
    parameter int DATA_W = 8,
    parameter int AW     = 14
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [2**AW];
    logic [DATA_W-1:0] rdata_q, rdata_d;

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // mem is sampled before this edge's write lands, giving read-first behaviour
    always_comb begin
        rdata_d = rdata_q;
        if (re) rdata_d = mem[raddr];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) rdata_q <= '0;
        else       rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;
endmodule

// File: rtl/sdp_ram_banked.sv
// Banked simple dual-port RAM top: bank decode, read mux, optional output stage.
// Optional post-reset zero fill is compiled in with SDP_RAM_INIT_CLEAR_EN.
module sdp_ram_banked
    import sdp_ram_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 15,
    parameter int BANK_AW = 14,
    parameter int OUT_REG = 1
) (
    input  logic             clk,
    input  logic             reset,
    sdp_ram_banked_if.slave  bus
);
    localparam int NB = nb(ADDR_W, BANK_AW);
    localparam int SW = (NB > 1) ? $clog2(NB) : 1;

    logic              busy;
    logic              rd_acc;
    logic              wvalid;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic [SW-1:0]     wr_bank, rd_bank;
    logic [SW-1:0]     bsel_q, bsel_d;
    logic [NB-1:0][DATA_W-1:0] bank_dout;
    logic [DATA_W-1:0] s1_data;

`ifdef SDP_RAM_INIT_CLEAR_EN
    clr_state_e        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == CLEAR) begin
            cnt_d = cnt_q + ADDR_W'(1);
            if (cnt_q == {ADDR_W{1'b1}}) state_d = IDLE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // while clearing, the engine owns the write port and user writes are dropped
    assign busy   = (state_q == CLEAR);
    assign wvalid = busy | bus.wr_en;
    assign waddr  = busy ? cnt_q : bus.wr_addr;
    assign wdata  = busy ? '0    : bus.wr_data;
`else
    assign busy   = 1'b0;
    assign wvalid = bus.wr_en;
    assign waddr  = bus.wr_addr;
    assign wdata  = bus.wr_data;
`endif

    assign rd_acc  = bus.rd_en & ~busy;
    assign wr_bank = SW'(waddr >> BANK_AW);
    assign rd_bank = SW'(bus.rd_addr >> BANK_AW);

    for (genvar g = 0; g < NB; g++) begin : g_bank
        sdp_ram_bank #(.DATA_W(DATA_W), .AW(BANK_AW)) u_bank (
            .clk   (clk),
            .reset (reset),
            .we    (wvalid && (wr_bank == SW'(g))),
            .waddr (waddr[BANK_AW-1:0]),
            .wdata (wdata),
            .re    (rd_acc && (rd_bank == SW'(g))),
            .raddr (bus.rd_addr[BANK_AW-1:0]),
            .rdata (bank_dout[g])
        );
    end

    always_comb begin
        bsel_d = bsel_q;
        if (rd_acc) bsel_d = rd_bank;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) bsel_q <= '0;
        else       bsel_q <= bsel_d;
    end

    assign s1_data = bank_dout[bsel_q];

    if (OUT_REG != 0) begin : g_oreg
        logic              v1_q, v1_d, vld_q, vld_d;
        logic [DATA_W-1:0] dout_q, dout_d;

        // a stage-1 word stalled by oce=0 stays pending until stage 2 takes it
        always_comb begin
            v1_d   = rd_acc | (v1_q & ~bus.oce);
            vld_d  = v1_q & bus.oce;
            dout_d = bus.oce ? s1_data : dout_q;
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                v1_q   <= 1'b0;
                vld_q  <= 1'b0;
                dout_q <= '0;
            end else begin
                v1_q   <= v1_d;
                vld_q  <= vld_d;
                dout_q <= dout_d;
            end
        end

        assign bus.rd_data  = dout_q;
        assign bus.rd_valid = vld_q;
    end else begin : g_noreg
        logic vld_q, vld_d;
        logic unused_oce;

        assign unused_oce = bus.oce;
        assign vld_d      = rd_acc;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) vld_q <= 1'b0;
            else       vld_q <= vld_d;
        end

        assign bus.rd_data  = s1_data;
        assign bus.rd_valid = vld_q;
    end

    assign bus.init_busy = busy;
endmodule

// File: tb/tb_sdp_ram_banked.sv
// Directed bench: OUT_REG=0 and OUT_REG=1 instances share one stimulus stream.
module tb_sdp_ram_banked;
    logic       clk = 1'b0;
    logic       reset;
    logic       wr_en, rd_en, oce;
    logic [3:0] wr_addr, rd_addr;
    logic [7:0] wr_data;
    int         n_pass = 0;
    int         n_tot  = 0;

    always #5 clk = ~clk;

    sdp_ram_banked_if #(.DATA_W(8), .ADDR_W(4)) if0 ();
    sdp_ram_banked_if #(.DATA_W(8), .ADDR_W(4)) if1 ();

    assign if0.wr_en = wr_en;  assign if1.wr_en = wr_en;
    assign if0.wr_addr = wr_addr;  assign if1.wr_addr = wr_addr;
    assign if0.wr_data = wr_data;  assign if1.wr_data = wr_data;
    assign if0.rd_en = rd_en;  assign if1.rd_en = rd_en;
    assign if0.rd_addr = rd_addr;  assign if1.rd_addr = rd_addr;
    assign if0.oce = 1'b1;
    assign if1.oce = oce;

    sdp_ram_banked #(.DATA_W(8), .ADDR_W(4), .BANK_AW(3), .OUT_REG(0)) dut0 (
        .clk(clk), .reset(reset), .bus(if0));
    sdp_ram_banked #(.DATA_W(8), .ADDR_W(4), .BANK_AW(3), .OUT_REG(1)) dut1 (
        .clk(clk), .reset(reset), .bus(if1));

`ifdef SDP_RAM_INIT_CLEAR_EN
    localparam logic EXP_BUSY = 1'b1;
`else
    localparam logic EXP_BUSY = 1'b0;
`endif

    typedef struct {
        logic       we;
        logic [3:0] wa;
        logic [7:0] wd;
        logic       re;
        logic [3:0] ra;
        logic       ev;
        logic [7:0] ed;
    } vec_t;

    vec_t tbl[15];

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        else n_pass++;
    endtask

    initial begin
        int   n;
        logic saw;
        logic pv;
        logic [7:0] pd;

        // expected values are for the latency-1 instance; row i follows row i's edge
        tbl[0]  = '{1'b1, 4'h2, 8'hA5, 1'b0, 4'h0, 1'b0, 8'h00};
        tbl[1]  = '{1'b1, 4'hA, 8'h5A, 1'b0, 4'h0, 1'b0, 8'h00};
        tbl[2]  = '{1'b0, 4'h0, 8'h00, 1'b1, 4'h2, 1'b1, 8'hA5};
        tbl[3]  = '{1'b0, 4'h0, 8'h00, 1'b1, 4'hA, 1'b1, 8'h5A};
        tbl[4]  = '{1'b0, 4'h0, 8'h00, 1'b0, 4'h0, 1'b0, 8'h5A};
        tbl[5]  = '{1'b1, 4'h5, 8'h11, 1'b0, 4'h0, 1'b0, 8'h5A};
        tbl[6]  = '{1'b1, 4'h5, 8'h33, 1'b1, 4'h5, 1'b1, 8'h11};
        tbl[7]  = '{1'b0, 4'h0, 8'h00, 1'b1, 4'h5, 1'b1, 8'h33};
        tbl[8]  = '{1'b1, 4'hF, 8'h7E, 1'b1, 4'h2, 1'b1, 8'hA5};
        tbl[9]  = '{1'b0, 4'h0, 8'h00, 1'b1, 4'hF, 1'b1, 8'h7E};
        tbl[10] = '{1'b1, 4'h0, 8'h01, 1'b0, 4'h0, 1'b0, 8'h7E};
        tbl[11] = '{1'b1, 4'h8, 8'h42, 1'b0, 4'h0, 1'b0, 8'h7E};
        tbl[12] = '{1'b0, 4'h0, 8'h00, 1'b1, 4'h0, 1'b1, 8'h01};
        tbl[13] = '{1'b0, 4'h0, 8'h00, 1'b1, 4'h8, 1'b1, 8'h42};
        tbl[14] = '{1'b0, 4'h0, 8'h00, 1'b0, 4'h0, 1'b0, 8'h42};

        reset = 1'b1; wr_en = 1'b0; rd_en = 1'b0; oce = 1'b1;
        wr_addr = '0; rd_addr = '0; wr_data = '0;
        repeat (2) cyc();
        chk("rst_data0", if0.rd_data, 8'h00);
        chk("rst_valid0", if0.rd_valid, 1'b0);
        chk("rst_busy0", if0.init_busy, EXP_BUSY);
        chk("rst_data1", if1.rd_data, 8'h00);
        chk("rst_valid1", if1.rd_valid, 1'b0);
        chk("rst_busy1", if1.init_busy, EXP_BUSY);
        reset = 1'b0;

`ifdef SDP_RAM_INIT_CLEAR_EN
        wr_en = 1'b1; wr_addr = 4'h3; wr_data = 8'hFF; rd_en = 1'b1; rd_addr = 4'h3;
        n = 0; saw = 1'b0;
        while (if0.init_busy && n < 40) begin
            cyc(); n++;
            if (if0.rd_valid || if1.rd_valid) saw = 1'b1;
        end
        wr_en = 1'b0; rd_en = 1'b0;
        chk("busy_cycles", n, 16);
        chk("busy_no_valid", saw, 1'b0);

        reset = 1'b1; cyc(); reset = 1'b0;
        repeat (7) cyc();
        chk("busy_at_7", if0.init_busy, 1'b1);
        reset = 1'b1; #1;
        chk("busy_in_rst", if0.init_busy, 1'b1);
        cyc(); reset = 1'b0;
        n = 0;
        while (if0.init_busy && n < 40) begin cyc(); n++; end
        chk("busy_restart", n, 16);

        for (int i = 0; i < 16; i++) begin
            rd_en = 1'b1; rd_addr = 4'(i);
            cyc();
            chk("clr_data", if0.rd_data, 8'h00);
            chk("clr_valid", if0.rd_valid, 1'b1);
        end
        rd_en = 1'b0;
`endif

        repeat (2) cyc();
        pv = 1'b0; pd = 8'h00;
        for (int i = 0; i < 15; i++) begin
            wr_en = tbl[i].we; wr_addr = tbl[i].wa; wr_data = tbl[i].wd;
            rd_en = tbl[i].re; rd_addr = tbl[i].ra;
            cyc();
            chk($sformatf("v%0d_data0", i), if0.rd_data, tbl[i].ed);
            chk($sformatf("v%0d_valid0", i), if0.rd_valid, tbl[i].ev);
            chk($sformatf("v%0d_data1", i), if1.rd_data, pd);
            chk($sformatf("v%0d_valid1", i), if1.rd_valid, pv);
            pv = tbl[i].ev; pd = tbl[i].ed;
        end
        wr_en = 1'b0; rd_en = 1'b0;

        // oce stall: stage 2 holds 0x42 while a read of 0x5A waits in stage 1
        rd_en = 1'b1; rd_addr = 4'hA; oce = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            rd_en = 1'b0;
            chk("stall_data", if1.rd_data, 8'h42);
            chk("stall_valid", if1.rd_valid, 1'b0);
        end
        oce = 1'b1;
        cyc();
        chk("unstall_data", if1.rd_data, 8'h5A);

        rd_en = 1'b1; rd_addr = 4'h2;
        cyc();
        rd_en = 1'b0;
        chk("lat2_e1_valid", if1.rd_valid, 1'b0);
        chk("lat2_e1_data", if1.rd_data, 8'h5A);
        cyc();
        chk("lat2_e2_valid", if1.rd_valid, 1'b1);
        chk("lat2_e2_data", if1.rd_data, 8'hA5);
        cyc();
        chk("lat2_pulse", if1.rd_valid, 1'b0);

        // reset with two reads in flight
        rd_en = 1'b1; rd_addr = 4'h2;
        cyc();
        rd_addr = 4'hA;
        cyc();
        rd_en = 1'b0;
        reset = 1'b1; #1;
        chk("flush_data1", if1.rd_data, 8'h00);
        chk("flush_valid1", if1.rd_valid, 1'b0);
        chk("flush_data0", if0.rd_data, 8'h00);
        chk("flush_valid0", if0.rd_valid, 1'b0);
        cyc();
        reset = 1'b0;
        saw = 1'b0;
        repeat (4) begin
            cyc();
            if (if0.rd_valid || if1.rd_valid) saw = 1'b1;
        end
        chk("no_late_valid", saw, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
